// File: rtl/window_scan_ctrl_if.sv
// Pixel-memory read bus: the scan controller issues byte reads
// and receives in-order returns with any latency of one cycle or more.
interface window_scan_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [7:0]        mem_rdata;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/window_scan_ctrl.sv
// Serpentine 9x9 window scanner: fills a window buffer column by column, then
// walks it across the image one column or one row per move, fetching 9 pixels each step.
module window_scan_ctrl #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    window_scan_ctrl_if.master mem,
    output logic              nineXnine_enable,
    output logic [1:0]        gauss_shift,
    output logic [7:0]        sram_inA,
    output logic [7:0]        sram_inB,
    output logic [7:0]        sram_inC,
    output logic [7:0]        sram_inD,
    output logic [7:0]        sram_inE,
    output logic [7:0]        sram_inF,
    output logic [7:0]        sram_inG,
    output logic [7:0]        sram_inH,
    output logic [7:0]        sram_inI,
    input  logic              win_ready,
    output logic              window_valid,
    output logic [ADDR_W-1:0] win_x,
    output logic [ADDR_W-1:0] win_y,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        PRESENT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        MV_NONE  = 2'b00,
        MV_RIGHT = 2'b01,
        MV_LEFT  = 2'b10,
        MV_DOWN  = 2'b11
    } move_t;

    localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_W - 9);
    localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(IMG_H - 9);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] SPAN   = ADDR_W'(9);
    localparam logic [3:0]        NINE   = 4'd9;

    state_t            state, state_nx;
    move_t             move, move_nx;
    logic [ADDR_W-1:0] fetch_col, fetch_col_nx;
    logic [3:0]        fill_cnt;
    logic [3:0]        issue_cnt;
    logic [3:0]        beat_cnt;
    logic              dir_left;
    logic [7:0]        slot [9];

    logic              issue;
    logic              beat_take;
    logic              last_beat;
    logic              filling;
    logic [ADDR_W-1:0] row_idx;
    logic [ADDR_W-1:0] col_idx;

    assign filling   = (fill_cnt < NINE);
    assign issue     = (state == FETCH) && (issue_cnt < NINE);
    // A beat can never precede its own issue, so beats beyond the issue count
    // are leftovers from a fetch abandoned by reset.
    assign beat_take = (state == FETCH) && mem.mem_rvalid && (beat_cnt < issue_cnt);
    assign last_beat = beat_take && (beat_cnt == 4'd8);

    assign row_idx = (move == MV_DOWN) ? (win_y + SPAN) : (win_y + ADDR_W'(issue_cnt));
    assign col_idx = (move == MV_DOWN) ? (win_x + ADDR_W'(issue_cnt)) : fetch_col;

    assign mem.mem_rd_en = issue;
    assign mem.mem_addr  = issue ? (row_idx * STRIDE + col_idx) : '0;

    assign sram_inA = slot[0];
    assign sram_inB = slot[1];
    assign sram_inC = slot[2];
    assign sram_inD = slot[3];
    assign sram_inE = slot[4];
    assign sram_inF = slot[5];
    assign sram_inG = slot[6];
    assign sram_inH = slot[7];
    assign sram_inI = slot[8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx         = state;
        move_nx          = move;
        fetch_col_nx     = fetch_col;
        nineXnine_enable = 1'b0;
        gauss_shift      = 2'b00;
        window_valid     = 1'b0;
        busy             = 1'b0;
        frame_done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx     = FETCH;
                    move_nx      = MV_RIGHT;
                    fetch_col_nx = '0;
                end
            end
            FETCH: begin
                busy = 1'b1;
                if (last_beat) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                busy             = 1'b1;
                nineXnine_enable = 1'b1;
                gauss_shift      = move;
                // fill_cnt still holds the pre-increment value here
                if (fill_cnt < 4'd8) begin
                    state_nx     = FETCH;
                    fetch_col_nx = ADDR_W'(fill_cnt) + ADDR_W'(1);
                end else begin
                    state_nx = PRESENT;
                end
            end
            PRESENT: begin
                busy         = 1'b1;
                window_valid = 1'b1;
                if (win_ready) begin
                    if (!dir_left && (win_x < X_LAST)) begin
                        state_nx     = FETCH;
                        move_nx      = MV_RIGHT;
                        fetch_col_nx = win_x + SPAN;
                    end else if (dir_left && (win_x != '0)) begin
                        state_nx     = FETCH;
                        move_nx      = MV_LEFT;
                        fetch_col_nx = win_x - ADDR_W'(1);
                    end else if (win_y < Y_LAST) begin
                        state_nx = FETCH;
                        move_nx  = MV_DOWN;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            move      <= MV_NONE;
            fetch_col <= '0;
            fill_cnt  <= '0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
            dir_left  <= 1'b0;
            win_x     <= '0;
            win_y     <= '0;
            for (int unsigned k = 0; k < 9; k++) begin
                slot[k] <= '0;
            end
        end else begin
            move      <= move_nx;
            fetch_col <= fetch_col_nx;

            if ((state == IDLE) && start) begin
                fill_cnt <= '0;
                dir_left <= 1'b0;
                win_x    <= '0;
                win_y    <= '0;
            end

            if ((state_nx == FETCH) && (state != FETCH)) begin
                issue_cnt <= '0;
                beat_cnt  <= '0;
            end else begin
                if (issue) begin
                    issue_cnt <= issue_cnt + 4'd1;
                end
                if (beat_take) begin
                    beat_cnt <= beat_cnt + 4'd1;
                end
            end

            for (int unsigned k = 0; k < 9; k++) begin
                if (beat_take && (beat_cnt == 4'(k))) begin
                    slot[k] <= mem.mem_rdata;
                end
            end

            // Window position moves in the strobe cycle so it is settled by PRESENT.
            if (state == SHIFT) begin
                if (filling) begin
                    fill_cnt <= fill_cnt + 4'd1;
                end else begin
                    unique case (move)
                        MV_RIGHT: win_x <= win_x + ADDR_W'(1);
                        MV_LEFT:  win_x <= win_x - ADDR_W'(1);
                        MV_DOWN: begin
                            win_y    <= win_y + ADDR_W'(1);
                            dir_left <= ~dir_left;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl on a 10x10 image with a variable-latency
// pixel memory whose contents are a fixed function of the address.
`timescale 1ns/1ps
module tb_window_scan_ctrl;

    localparam int W      = 10;
    localparam int H      = 10;
    localparam int AW     = 16;
    localparam int N_ADDR = 108;
    localparam int N_MOVE = 12;
    localparam int N_WIN  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          win_ready = 1'b0;
    logic          nineXnine_enable;
    logic [1:0]    gauss_shift;
    logic [7:0]    sram_inA, sram_inB, sram_inC, sram_inD, sram_inE;
    logic [7:0]    sram_inF, sram_inG, sram_inH, sram_inI;
    logic          window_valid;
    logic [AW-1:0] win_x, win_y;
    logic          busy;
    logic          frame_done;

    window_scan_ctrl_if #(.ADDR_W(AW)) mem ();

    window_scan_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .mem              (mem),
        .nineXnine_enable (nineXnine_enable),
        .gauss_shift      (gauss_shift),
        .sram_inA         (sram_inA),
        .sram_inB         (sram_inB),
        .sram_inC         (sram_inC),
        .sram_inD         (sram_inD),
        .sram_inE         (sram_inE),
        .sram_inF         (sram_inF),
        .sram_inG         (sram_inG),
        .sram_inH         (sram_inH),
        .sram_inI         (sram_inI),
        .win_ready        (win_ready),
        .window_valid     (window_valid),
        .win_x            (win_x),
        .win_y            (win_y),
        .busy             (busy),
        .frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input logic [AW-1:0] a);
        return a[7:0] * 8'd3 + 8'h5A;
    endfunction

    // Memory: read requests travel down a pipe; rvalid taps it at the chosen latency.
    int            lat = 1;
    logic          inj = 1'b0;
    logic [3:0]    pv = '0;
    logic [AW-1:0] pa [4];

    always @(posedge clk) begin
        pv    <= {pv[2:0], mem.mem_rd_en};
        pa[0] <= mem.mem_addr;
        for (int i = 1; i < 4; i++) pa[i] <= pa[i-1];
    end

    assign mem.mem_rvalid = pv[lat-1] | inj;
    assign mem.mem_rdata  = inj ? 8'hEE : (pv[lat-1] ? pix(pa[lat-1]) : 8'h00);

    wire [71:0]  slots_now = {sram_inA, sram_inB, sram_inC, sram_inD, sram_inE,
                              sram_inF, sram_inG, sram_inH, sram_inI};
    wire [126:0] all_outs  = {mem.mem_rd_en, mem.mem_addr, nineXnine_enable, gauss_shift,
                              slots_now, window_valid, win_x, win_y, busy, frame_done};

    int            cyc = 0;
    logic [AW-1:0] addr_q [$];
    logic [1:0]    code_q [$];
    logic [71:0]   slot_q [$];
    logic [31:0]   win_q [$];
    int            beat_cyc_q [$];
    int            shift_cyc_q [$];
    int            done_cnt = 0;
    int            busy_at_done = 0;

    always @(negedge clk) begin
        cyc++;
        if (mem.mem_rd_en) addr_q.push_back(mem.mem_addr);
        if (pv[lat-1]) beat_cyc_q.push_back(cyc);
        if (nineXnine_enable) begin
            code_q.push_back(gauss_shift);
            slot_q.push_back(slots_now);
            shift_cyc_q.push_back(cyc);
        end
        if (window_valid && win_ready) win_q.push_back({win_x, win_y});
        if (frame_done) begin
            done_cnt++;
            if (busy) busy_at_done++;
        end
    end

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] exp_addr [N_ADDR];
    logic [1:0]    exp_code [N_MOVE];
    logic [31:0]   exp_win [N_WIN];

    task automatic build_expected();
        int n;
        n = 0;
        for (int c = 0; c < 9; c++)
            for (int k = 0; k < 9; k++) begin exp_addr[n] = AW'(c + 10 * k); n++; end
        for (int k = 0; k < 9; k++) begin exp_addr[n] = AW'(9 + 10 * k); n++; end
        for (int k = 0; k < 9; k++) begin exp_addr[n] = AW'(91 + k); n++; end
        for (int k = 0; k < 9; k++) begin exp_addr[n] = AW'(10 + 10 * k); n++; end
        for (int j = 0; j < 10; j++) exp_code[j] = 2'b01;
        exp_code[10] = 2'b11;
        exp_code[11] = 2'b10;
        exp_win[0] = {16'd0, 16'd0};
        exp_win[1] = {16'd1, 16'd0};
        exp_win[2] = {16'd1, 16'd1};
        exp_win[3] = {16'd0, 16'd1};
    endtask

    function automatic logic [71:0] exp_slots(input int j);
        logic [71:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) v = {v[63:0], pix(exp_addr[9 * j + k])};
        return v;
    endfunction

    task automatic clear_logs();
        addr_q.delete();
        code_q.delete();
        slot_q.delete();
        win_q.delete();
        beat_cyc_q.delete();
        shift_cyc_q.delete();
        done_cnt = 0;
        busy_at_done = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_outs: got %h expected 0", all_outs);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL idle_outs: got %h expected 0", all_outs);
        end
    endtask

    // Full frame with win_ready held high; checks addresses, codes, slots, windows, done.
    task automatic test_frame(input int lat_i, input string tag);
        int bad;
        lat = lat_i;
        win_ready = 1'b1;
        clear_logs();
        pulse_start();
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s done_timeout: got no frame_done expected one", tag);
        end
        repeat (5) @(negedge clk);
        win_ready = 1'b0;
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s done_count: got %0d expected 1", tag, done_cnt);
        end
        checks++;
        if (busy_at_done != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done: got %0d expected 0", tag, busy_at_done);
        end
        checks++;
        if (addr_q.size() != N_ADDR) begin
            errors++;
            $display("FAIL %s addr_count: got %0d expected %0d", tag, addr_q.size(), N_ADDR);
        end else begin
            bad = -1;
            for (int i = 0; i < N_ADDR; i++) if (bad < 0 && addr_q[i] !== exp_addr[i]) bad = i;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL %s addr[%0d]: got %0d expected %0d", tag, bad, addr_q[bad], exp_addr[bad]);
            end
        end
        checks++;
        if (code_q.size() != N_MOVE) begin
            errors++;
            $display("FAIL %s strobe_count: got %0d expected %0d", tag, code_q.size(), N_MOVE);
        end else begin
            for (int j = 0; j < N_MOVE; j++) begin
                checks++;
                if (code_q[j] !== exp_code[j] || slot_q[j] !== exp_slots(j)) begin
                    errors++;
                    $display("FAIL %s move[%0d]: got code %b slots %h expected code %b slots %h",
                             tag, j, code_q[j], slot_q[j], exp_code[j], exp_slots(j));
                end
            end
        end
        checks++;
        if (win_q.size() != N_WIN) begin
            errors++;
            $display("FAIL %s window_count: got %0d expected %0d", tag, win_q.size(), N_WIN);
        end else begin
            for (int w = 0; w < N_WIN; w++) begin
                checks++;
                if (win_q[w] !== exp_win[w]) begin
                    errors++;
                    $display("FAIL %s window[%0d]: got %h expected %h", tag, w, win_q[w], exp_win[w]);
                end
            end
        end
    endtask

    task automatic test_latency();
        int bad;
        test_frame(4, "lat4");
        checks++;
        if (beat_cyc_q.size() != N_ADDR || shift_cyc_q.size() != N_MOVE) begin
            errors++;
            $display("FAIL lat4_timing_counts: got beats %0d strobes %0d expected %0d %0d",
                     beat_cyc_q.size(), shift_cyc_q.size(), N_ADDR, N_MOVE);
        end else begin
            bad = -1;
            for (int j = 0; j < N_MOVE; j++)
                if (bad < 0 && shift_cyc_q[j] != beat_cyc_q[9 * j + 8] + 1) bad = j;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL lat4_shift_delay[%0d]: got strobe at %0d expected %0d",
                         bad, shift_cyc_q[bad], beat_cyc_q[9 * bad + 8] + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pos;
        logic        seen;
        lat = 1;
        win_ready = 1'b0;
        clear_logs();
        pulse_start();
        for (int w = 0; w < N_WIN; w++) begin
            seen = 1'b0;
            for (int i = 0; i < 300 && !seen; i++) begin
                @(negedge clk);
                seen = window_valid;
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL bp_window_timeout[%0d]: got no window_valid expected one", w);
                return;
            end
            pos = {win_x, win_y};
            checks++;
            if (pos !== exp_win[w]) begin
                errors++;
                $display("FAIL bp_position[%0d]: got %h expected %h", w, pos, exp_win[w]);
            end
            if (w == 1) begin
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    checks++;
                    if (window_valid !== 1'b1 || mem.mem_rd_en !== 1'b0 ||
                        nineXnine_enable !== 1'b0 || {win_x, win_y} !== pos) begin
                        errors++;
                        $display("FAIL bp_hold[%0d]: got valid %b rd %b strobe %b pos %h expected 1 0 0 %h",
                                 c, window_valid, mem.mem_rd_en, nineXnine_enable, {win_x, win_y}, pos);
                    end
                end
            end
            @(posedge clk); #1 win_ready = 1'b1;
            @(posedge clk); #1 win_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (window_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_valid_drop[%0d]: got %b expected 0", w, window_valid);
            end
        end
        for (int i = 0; i < 20 && done_cnt == 0; i++) @(negedge clk);
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL bp_done: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_reset_midfetch();
        int n;
        lat = 3;
        win_ready = 1'b1;
        clear_logs();
        pulse_start();
        n = 0;
        for (int i = 0; i < 50 && n < 5; i++) begin
            @(negedge clk);
            if (mem.mem_rd_en) n++;
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL rst_issue_reach: got %0d issues expected 5", n);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL rst_midfetch_outs: got %h expected 0", all_outs);
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (all_outs !== '0) begin
                errors++;
                $display("FAIL rst_stale_beat[%0d]: got %h expected 0", c, all_outs);
            end
        end
        win_ready = 1'b0;
        test_frame(1, "restart");
    endtask

    task automatic test_start_busy_spurious();
        logic seen;
        lat = 1;
        win_ready = 1'b0;
        clear_logs();
        pulse_start();
        repeat (4) @(negedge clk);
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = window_valid;
        end
        checks++;
        if (!seen || {win_x, win_y} !== exp_win[0]) begin
            errors++;
            $display("FAIL sb_first_window: got valid %b pos %h expected 1 %h",
                     seen, {win_x, win_y}, exp_win[0]);
        end
        pulse_start();
        @(posedge clk); #1 inj = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 inj = 1'b0;
        @(negedge clk);
        checks++;
        if (slots_now !== exp_slots(8)) begin
            errors++;
            $display("FAIL sb_spurious_slots: got %h expected %h", slots_now, exp_slots(8));
        end
        checks++;
        if (window_valid !== 1'b1 || mem.mem_rd_en !== 1'b0 || {win_x, win_y} !== exp_win[0]) begin
            errors++;
            $display("FAIL sb_present_hold: got valid %b rd %b pos %h expected 1 0 %h",
                     window_valid, mem.mem_rd_en, {win_x, win_y}, exp_win[0]);
        end
        win_ready = 1'b1;
        for (int i = 0; i < 500 && done_cnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        win_ready = 1'b0;
        checks++;
        if (done_cnt != 1 || addr_q.size() != N_ADDR || code_q.size() != N_MOVE) begin
            errors++;
            $display("FAIL sb_sequence_len: got done %0d addrs %0d strobes %0d expected 1 %0d %0d",
                     done_cnt, addr_q.size(), code_q.size(), N_ADDR, N_MOVE);
        end else begin
            for (int i = 0; i < N_ADDR; i += 9) begin
                checks++;
                if (addr_q[i] !== exp_addr[i]) begin
                    errors++;
                    $display("FAIL sb_addr[%0d]: got %0d expected %0d", i, addr_q[i], exp_addr[i]);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        build_expected();
        test_reset();
        test_frame(1, "serpentine");
        test_backpressure();
        test_latency();
        test_reset_midfetch();
        test_start_busy_spurious();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
